// File: rtl/prog_uart_pkg.sv
// Shared constants for the UART program loader / dumper pair.
package prog_uart_pkg;

   localparam int unsigned OVERSAMPLE = 12;
   localparam int unsigned ADR_W      = 21;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_clk-domain 8N1 transmitter, owns the receiving side of the toggle handshake.
module uart_tx_byte
   import prog_uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = prog_uart_pkg::OVERSAMPLE
) (
   input  logic       uart_clk,
   input  logic       reset,
   input  logic [7:0] byte_reg,
   input  logic       req_seq,
   output logic       ack_seq,
   output logic       tx
);

   localparam int unsigned      OS_W    = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);

   logic            req_meta;
   logic            req_sync;
   logic [1:0]      state;
   logic [OS_W-1:0] os_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shifter;

   // Two-flop synchronizer bringing req_seq into the uart_clk domain.
   always_ff @(posedge uart_clk) begin
      if (reset) begin
         req_meta <= 1'b0;
         req_sync <= 1'b0;
      end else begin
         req_meta <= req_seq;
         req_sync <= req_meta;
      end
   end

   // Frame generator: start bit, 8 data bits LSB first, stop bit, then ack toggle.
   always_ff @(posedge uart_clk) begin
      if (reset) begin
         state   <= TX_IDLE;
         os_cnt  <= '0;
         bit_cnt <= '0;
         shifter <= '0;
         tx      <= 1'b1;
         ack_seq <= 1'b0;
      end else begin
         case (state)
            TX_IDLE: begin
               tx     <= 1'b1;
               os_cnt <= '0;
               if (req_sync != ack_seq) begin
                  shifter <= byte_reg;
                  tx      <= 1'b0;
                  state   <= TX_START;
               end
            end
            TX_START: begin
               if (os_cnt == OS_LAST) begin
                  os_cnt  <= '0;
                  bit_cnt <= '0;
                  tx      <= shifter[0];
                  shifter <= {1'b0, shifter[7:1]};
                  state   <= TX_DATA;
               end else begin
                  os_cnt <= os_cnt + OS_W'(1);
               end
            end
            TX_DATA: begin
               if (os_cnt == OS_LAST) begin
                  os_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     tx    <= 1'b1;
                     state <= TX_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= shifter[0];
                     shifter <= {1'b0, shifter[7:1]};
                  end
               end else begin
                  os_cnt <= os_cnt + OS_W'(1);
               end
            end
            TX_STOP: begin
               if (os_cnt == OS_LAST) begin
                  os_cnt  <= '0;
                  ack_seq <= ~ack_seq;
                  state   <= TX_IDLE;
               end else begin
                  os_cnt <= os_cnt + OS_W'(1);
               end
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/prog_dumper.sv
// Program memory reader feeding a uart_clk-domain transmitter via toggle handshake.
module prog_dumper
   import prog_uart_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned OVERSAMPLE = prog_uart_pkg::OVERSAMPLE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [ADR_W-1:0] base,
   input  logic [ADR_W-1:0] len,
   output logic [ADR_W-1:0] adr,
   output logic             read,
   input  logic [7:0]       din,
   output logic             busy,
   output logic             done,
   input  logic             uart_clk,
   output logic             tx
);

   localparam logic [1:0] RD_IDLE = 2'd0;
   localparam logic [1:0] RD_ADDR = 2'd1;
   localparam logic [1:0] RD_WAIT = 2'd2;
   localparam logic [1:0] RD_HAND = 2'd3;

   localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

   logic [1:0]       state;
   logic [ADR_W-1:0] remaining;
   logic [2:0]       lat_cnt;
   logic [7:0]       byte_reg;
   logic             req_seq;
   logic             ack_seq;
   logic             ack_meta;
   logic             ack_sync;

   // Two-flop synchronizer returning ack_seq to the clk domain.
   always_ff @(posedge clk) begin
      if (reset) begin
         ack_meta <= 1'b0;
         ack_sync <= 1'b0;
      end else begin
         ack_meta <= ack_seq;
         ack_sync <= ack_meta;
      end
   end

   // Read sequencer: address, wait for memory, hand byte over, wait for ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RD_IDLE;
         adr       <= '0;
         remaining <= '0;
         lat_cnt   <= '0;
         byte_reg  <= '0;
         req_seq   <= 1'b0;
         read      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         read <= 1'b0;
         done <= 1'b0;
         case (state)
            RD_IDLE: begin
               if (start) begin
                  adr       <= base;
                  remaining <= len;
                  if (len == '0) begin
                     done <= 1'b1;
                  end else begin
                     busy  <= 1'b1;
                     read  <= 1'b1;
                     state <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               lat_cnt <= '0;
               state   <= RD_WAIT;
            end
            RD_WAIT: begin
               if (lat_cnt == LAT_LAST) begin
                  byte_reg <= din;
                  req_seq  <= ~req_seq;
                  state    <= RD_HAND;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            RD_HAND: begin
               if (ack_sync == req_seq) begin
                  remaining <= remaining - ADR_W'(1);
                  if (remaining == ADR_W'(1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= RD_IDLE;
                  end else begin
                     adr   <= adr + ADR_W'(1);
                     read  <= 1'b1;
                     state <= RD_ADDR;
                  end
               end
            end
            default: state <= RD_IDLE;
         endcase
      end
   end

   uart_tx_byte #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tx (
      .uart_clk (uart_clk),
      .reset    (reset),
      .byte_reg (byte_reg),
      .req_seq  (req_seq),
      .ack_seq  (ack_seq),
      .tx       (tx)
   );

endmodule

// File: tb/tb_prog_dumper.sv
// Scoreboard bench for prog_dumper: three instances (RD_LATENCY 2, 1, 4) share stimulus.
`timescale 1ns/1ps
module tb_prog_dumper;

   localparam int NI  = 3;
   localparam int OVS = 12;

   logic        clk      = 1'b0;
   logic        uart_clk = 1'b0;
   logic        reset    = 1'b1;
   logic        start    = 1'b0;
   logic [20:0] base     = '0;
   logic [20:0] len      = '0;

   realtime clk_half  = 5.0;
   realtime uclk_half = 5.2;

   always #(clk_half)  clk      = ~clk;
   always #(uclk_half) uart_clk = ~uart_clk;

   logic [20:0]   adr_w [NI];
   logic [7:0]    din_w [NI];
   logic [NI-1:0] read_w, busy_w, done_w, tx_w;

   bit [7:0]    mem [bit [20:0]];
   logic [20:0] exp_adr_q  [NI][$];
   logic [7:0]  exp_byte_q [NI][$];
   int          done_cnt   [NI];

   int checks   = 0;
   int failures = 0;

   function automatic logic [7:0] mem_rd(input logic [20:0] a);
      if (mem.exists(a)) return mem[a];
      return 8'h00;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic bit pending();
      for (int i = 0; i < NI; i++)
         if (exp_adr_q[i].size() != 0 || exp_byte_q[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g
      localparam int unsigned LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);

      logic [7:0]  pipe [LAT];
      logic        dec_active = 1'b0;
      int unsigned fc = 0;
      logic [9:0]  frame = '0;

      prog_dumper #(
         .RD_LATENCY (LAT)
      ) dut (
         .clk      (clk),
         .reset    (reset),
         .start    (start),
         .base     (base),
         .len      (len),
         .adr      (adr_w[gi]),
         .read     (read_w[gi]),
         .din      (din_w[gi]),
         .busy     (busy_w[gi]),
         .done     (done_w[gi]),
         .uart_clk (uart_clk),
         .tx       (tx_w[gi])
      );

      // Memory with LAT-cycle read pipeline; non-read slots carry a filler value.
      always @(posedge clk) begin
         pipe[0] <= read_w[gi] ? mem_rd(adr_w[gi]) : 8'hEE;
         for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
      end
      assign din_w[gi] = pipe[LAT-1];

      // Read-address monitor.
      always @(negedge clk) begin
         if (!reset && read_w[gi]) begin
            if (exp_adr_q[gi].size() == 0) begin
               checks++;
               failures++;
               $display("FAIL read_adr[%0d]: got unexpected read at %06h, expected none", gi, adr_w[gi]);
            end else begin
               chk($sformatf("read_adr[%0d]", gi), 32'(adr_w[gi]), 32'(exp_adr_q[gi].pop_front()));
            end
         end
      end

      // Done monitor: busy must already be low while done is high.
      always @(negedge clk) begin
         if (!reset && done_w[gi]) begin
            done_cnt[gi] <= done_cnt[gi] + 1;
            chk($sformatf("busy_at_done[%0d]", gi), 32'(busy_w[gi]), 32'(0));
         end
      end

      // UART decoder: samples mid-bit, checks start/data/stop of each frame.
      always @(negedge uart_clk) begin
         if (reset) begin
            dec_active <= 1'b0;
         end else if (!dec_active) begin
            if (tx_w[gi] == 1'b0) begin
               dec_active <= 1'b1;
               fc         <= 1;
            end
         end else begin
            fc <= fc + 1;
            if (fc % OVS == OVS / 2) frame[fc / OVS] <= tx_w[gi];
            if (fc == 9 * OVS + OVS / 2) begin
               dec_active <= 1'b0;
               if (exp_byte_q[gi].size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL tx_frame[%0d]: got unexpected frame data %02h, expected none", gi, frame[8:1]);
               end else begin
                  chk($sformatf("tx_frame[%0d]", gi), 32'({tx_w[gi], frame[8:0]}),
                      32'({1'b1, exp_byte_q[gi].pop_front(), 1'b0}));
               end
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      repeat (3) @(negedge clk);
      while (busy_w != '0 || pending()) begin
         @(negedge clk);
         n++;
         if (n > 20000) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: got still busy after %0d cycles, expected idle", n);
            for (int i = 0; i < NI; i++) begin
               exp_adr_q[i].delete();
               exp_byte_q[i].delete();
            end
            break;
         end
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic run_dump(input logic [20:0] b, input logic [20:0] n, input bit restart);
      int          d0 [NI];
      logic [20:0] a;
      for (int i = 0; i < NI; i++) d0[i] = done_cnt[i];
      for (int unsigned k = 0; k < n; k++) begin
         a = b + 21'(k);
         for (int i = 0; i < NI; i++) begin
            exp_adr_q[i].push_back(a);
            exp_byte_q[i].push_back(mem_rd(a));
         end
      end
      @(negedge clk);
      base  = b;
      len   = n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (restart) begin
         repeat (10) @(negedge clk);
         base  = 21'h40;
         len   = 21'd5;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_idle();
      for (int i = 0; i < NI; i++)
         chk($sformatf("done_count[%0d]", i), 32'(done_cnt[i] - d0[i]), 32'(1));
   endtask

   initial begin
      int   d0 [NI];
      logic busy_seen;
      int   n;

      mem[21'h10]     = 8'h55;
      mem[21'h11]     = 8'hA3;
      mem[21'h1FFFFF] = 8'h3C;
      mem[21'h000000] = 8'hC5;
      mem[21'h20]     = 8'h01;
      mem[21'h21]     = 8'h80;
      mem[21'h22]     = 8'hFF;
      mem[21'h30]     = 8'h96;
      mem[21'h31]     = 8'h69;
      mem[21'h40]     = 8'h77;
      mem[21'h50]     = 8'h00;
      mem[21'h51]     = 8'h5A;
      mem[21'h52]     = 8'hC3;

      repeat (4) @(negedge clk);
      repeat (3) @(negedge uart_clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rst_tx[%0d]", i),   32'(tx_w[i]),   32'(1));
         chk($sformatf("rst_busy[%0d]", i), 32'(busy_w[i]), 32'(0));
         chk($sformatf("rst_done[%0d]", i), 32'(done_w[i]), 32'(0));
         chk($sformatf("rst_read[%0d]", i), 32'(read_w[i]), 32'(0));
         chk($sformatf("rst_adr[%0d]", i),  32'(adr_w[i]),  32'(0));
      end
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Two-byte dump.
      run_dump(21'h10, 21'd2, 1'b0);
      for (int i = 0; i < NI; i++)
         chk($sformatf("adr_hold[%0d]", i), 32'(adr_w[i]), 32'(21'h11));

      // Zero length: done only.
      for (int i = 0; i < NI; i++) d0[i] = done_cnt[i];
      @(negedge clk);
      base  = 21'h10;
      len   = '0;
      start = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      busy_seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (busy_w != '0) busy_seen = 1'b1;
      end
      chk("len0_busy", 32'(busy_seen), 32'(0));
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("len0_done[%0d]", i), 32'(done_cnt[i] - d0[i]), 32'(1));
         chk($sformatf("len0_tx[%0d]", i),   32'(tx_w[i]),             32'(1));
      end

      // Address wrap at 21 bits.
      run_dump(21'h1FFFFF, 21'd2, 1'b0);

      // Second start while busy is ignored.
      run_dump(21'h20, 21'd3, 1'b1);

      // Reset during the 4th data bit of the first frame.
      for (int i = 0; i < NI; i++) exp_adr_q[i].push_back(21'h30);
      @(negedge clk);
      base  = 21'h30;
      len   = 21'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (tx_w[0] !== 1'b0 && n < 5000) begin
         @(negedge uart_clk);
         n++;
      end
      chk("midframe_start_seen", 32'(tx_w[0]), 32'(0));
      repeat (OVS + 3 * OVS + OVS / 2) @(negedge uart_clk);
      reset = 1'b1;
      @(negedge uart_clk);
      for (int i = 0; i < NI; i++)
         chk($sformatf("midrst_tx[%0d]", i), 32'(tx_w[i]), 32'(1));
      repeat (3) @(negedge clk);
      repeat (3) @(negedge uart_clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("midrst_busy[%0d]", i), 32'(busy_w[i]), 32'(0));
         chk($sformatf("midrst_adr[%0d]", i),  32'(adr_w[i]),  32'(0));
         chk($sformatf("midrst_reads[%0d]", i), 32'(exp_adr_q[i].size()), 32'(0));
         exp_adr_q[i].delete();
         exp_byte_q[i].delete();
      end
      reset = 1'b0;
      repeat (400) @(negedge uart_clk);
      for (int i = 0; i < NI; i++)
         chk($sformatf("post_rst_idle[%0d]", i), 32'(tx_w[i]), 32'(1));
      run_dump(21'h10, 21'd2, 1'b0);

      // Clock ratio 5:1 (clk faster).
      clk_half  = 5.0;
      uclk_half = 25.3;
      repeat (4) @(negedge uart_clk);
      run_dump(21'h50, 21'd3, 1'b0);

      // Clock ratio 1:3 (uart_clk faster).
      clk_half  = 15.0;
      uclk_half = 5.1;
      repeat (4) @(negedge clk);
      run_dump(21'h50, 21'd3, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5ms;
      failures++;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
